// File: rtl/mag_cmp_pkg.sv
// Shared types and sizing helpers for the iterative magnitude comparator.
package mag_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        GT   = 2'd1,
        LT   = 2'd2
    } dec_e;

    // Width of the chunk index counter; never narrower than one bit.
    function automatic int idx_w(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/mag_cmp_seq_cmp_chunk.sv
// Combinational CHUNK-bit magnitude comparator: gt and eq, resolved MSB first.
module cmp_chunk #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             gt,
    output logic             eq
);

    always_comb begin
        gt = 1'b0;
        eq = 1'b1;
        for (int i = CHUNK - 1; i >= 0; i--) begin
            if (eq) begin
                if (a[i] && !b[i]) begin
                    gt = 1'b1;
                    eq = 1'b0;
                end else if (!a[i] && b[i]) begin
                    eq = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/mag_cmp_seq.sv
// Iterative W-bit magnitude comparator, CHUNK bits per cycle MSB first.
// Define CMP_EARLY_EXIT_EN to finish on the first differing chunk.
module mag_cmp_seq
    import mag_cmp_pkg::*;
#(
    parameter int W     = 16,
    parameter int CHUNK = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         is_signed,
    output logic         ready,
    output logic         done,
    output logic         agtb,
    output logic         aeqb,
    output logic         altb
);

    localparam int NCHUNK = W / CHUNK;
    localparam int IW     = idx_w(NCHUNK);

    state_e          state_q, state_d;
    dec_e            dec_q, dec_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d;
    logic            agtb_q, agtb_d, aeqb_q, aeqb_d, altb_q, altb_d;

    logic [CHUNK-1:0] ca, cb;
    logic             c_gt, c_eq;
    logic             last;

    assign ca = a_q[int'(idx_q) * CHUNK +: CHUNK];
    assign cb = b_q[int'(idx_q) * CHUNK +: CHUNK];

    cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a  (ca),
        .b  (cb),
        .gt (c_gt),
        .eq (c_eq)
    );

`ifdef CMP_EARLY_EXIT_EN
    assign last = (idx_q == '0) || !c_eq;
`else
    assign last = (idx_q == '0);
`endif

    always_comb begin
        state_d = state_q;
        dec_d   = dec_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        agtb_d  = agtb_q;
        aeqb_d  = aeqb_q;
        altb_d  = altb_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    // Flipping the sign bit maps two's complement onto offset binary.
                    a_d        = a;
                    b_d        = b;
                    a_d[W-1]   = a[W-1] ^ is_signed;
                    b_d[W-1]   = b[W-1] ^ is_signed;
                    idx_d      = IW'(NCHUNK - 1);
                    dec_d      = NONE;
                    state_d    = CMP;
                end
            end
            CMP: begin
                if (dec_q == NONE) begin
                    if (c_gt)       dec_d = GT;
                    else if (!c_eq) dec_d = LT;
                end
                if (last) begin
                    // Flags load on the exit edge so they appear together with done.
                    state_d = DONE;
                    agtb_d  = (dec_d == GT);
                    altb_d  = (dec_d == LT);
                    aeqb_d  = (dec_d == NONE);
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            dec_q   <= NONE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            agtb_q  <= 1'b0;
            aeqb_q  <= 1'b0;
            altb_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dec_q   <= dec_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            agtb_q  <= agtb_d;
            aeqb_q  <= aeqb_d;
            altb_q  <= altb_d;
        end
    end

    assign ready = (state_q == IDLE);
    assign done  = (state_q == DONE);
    assign agtb  = agtb_q;
    assign aeqb  = aeqb_q;
    assign altb  = altb_q;

endmodule
